game_status_tx: RTL and testbench

Serial transmitter for the game board. It is the outgoing counterpart of the board's serial_in link.
- On request, it snapshots the current game state (lives, player positions, correct doors, timer) and frames it into a 5-byte packet.
- The packet is sent as UART 8N1 on serial_out.
- Runs in the VGA_CLK (25 MHz) domain beside the timer and screen_drawer, so the external controller can mirror the game state.

---
 rtl/game_link_pkg.sv | 46 ++++
 rtl/uart_tx_byte.sv | 113 +++++++++++
 rtl/game_status_tx.sv | 112 +++++++++++
 tb/tb_game_status_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_link_pkg.sv
// Shared definitions for the game-state serial link: packet layout, FSM states
// and the packing function reused by the receiver side.
package game_link_pkg;

  localparam logic [7:0]  PKT_HEADER = 8'hA5;
  localparam int unsigned PKT_LEN    = 5;

  typedef logic [PKT_LEN-1:0][7:0] pkt_t;

  typedef struct packed {
    logic [1:0] p1_lives;
    logic [1:0] p2_lives;
    logic [1:0] p1_pos;
    logic [1:0] p2_pos;
    logic [1:0] door_1;
    logic [1:0] door_2;
    logic       time_up;
    logic [3:0] seconds;
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_BYTE,
    ST_WAIT_BYTE
  } pkt_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

  // Byte 0 is sent first; byte 4 is the XOR checksum over bytes 1..3.
  function automatic pkt_t pack_status(input status_t s);
    pkt_t pkt;
    pkt[0] = PKT_HEADER;
    pkt[1] = {s.p1_lives, s.p2_lives, s.p1_pos, s.p2_pos};
    pkt[2] = {s.door_1, s.door_2, 4'b0000};
    pkt[3] = {s.time_up, 3'b000, s.seconds};
    pkt[4] = pkt[1] ^ pkt[2] ^ pkt[3];
    return pkt;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer. ready also rises in the last stop-bit cycle so a
// following byte starts with no gap; byte_done marks that same last cycle.
module uart_tx_byte
  import game_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned         BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]   BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  ser_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              byte_done_q, byte_done_d;
  logic              wrap_c;

  assign wrap_c    = (baud_q == BAUD_LAST);
  assign ready     = (state_q == S_IDLE) || ((state_q == S_STOP) && wrap_c);
  assign tx        = tx_q;
  assign byte_done = byte_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      tx_q        <= 1'b1;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    data_d      = data_q;
    tx_d        = tx_q;
    byte_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          state_d = S_START;
          baud_d  = '0;
          data_d  = data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (wrap_c) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (wrap_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (wrap_c) begin
          baud_d = '0;
          if (valid) begin
            state_d = S_START;
            data_d  = data;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d      = baud_q + BAUD_W'(1);
          byte_done_d = (baud_q == BAUD_PRE);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/game_status_tx.sv
// Snapshots the game state on send and streams it as a 5-byte UART packet.
// The header byte is launched in the accept cycle so the line starts next cycle.
module game_status_tx
  import game_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [1:0] p1_lives,
  input  logic [1:0] p2_lives,
  input  logic [1:0] player_1_pos,
  input  logic [1:0] player_2_pos,
  input  logic [1:0] correct_door_1,
  input  logic [1:0] correct_door_2,
  input  logic       time_up,
  input  logic [3:0] seconds,
  output logic       serial_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  pkt_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  status_t    snap_q, snap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  status_t    status_c;
  pkt_t       pkt_c;
  logic       ser_valid_c;
  logic [7:0] ser_data_c;
  logic       ser_ready;
  logic       ser_byte_done;

  assign status_c = {p1_lives, p2_lives, player_1_pos, player_2_pos,
                     correct_door_1, correct_door_2, time_up, seconds};
  assign pkt_c    = pack_status(snap_q);
  assign busy     = busy_q;
  assign done     = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .data      (ser_data_c),
    .valid     (ser_valid_c),
    .ready     (ser_ready),
    .tx        (serial_out),
    .byte_done (ser_byte_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next byte is offered while the current one sits in its final stop cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ser_valid_c = 1'b0;
    ser_data_c  = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (send) begin
          ser_valid_c = 1'b1;
          ser_data_c  = PKT_HEADER;
          snap_d      = status_c;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD:      state_d = ST_SEND_BYTE;
      ST_SEND_BYTE: state_d = ST_WAIT_BYTE;
      ST_WAIT_BYTE: begin
        if (idx_q != LAST_IDX) begin
          if (ser_ready) begin
            ser_valid_c = 1'b1;
            ser_data_c  = pkt_c[idx_q + 3'd1];
            idx_d       = idx_q + 3'd1;
            state_d     = ST_SEND_BYTE;
          end
        end else if (ser_byte_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_status_tx.sv
// Randomized scoreboard bench for game_status_tx: a line decoder pops expected
// bytes, start cycles and done cycles pushed by the stimulus side.
module tb_game_status_tx;

  localparam int unsigned C       = 4;
  localparam int unsigned H       = C / 2;
  localparam int unsigned PKT_CYC = 50 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_r = 1'b0;
  logic [1:0] p1_lives = '0, p2_lives = '0, p1_pos = '0, p2_pos = '0;
  logic [1:0] door_1 = '0, door_2 = '0;
  logic       time_up = 1'b0;
  logic [3:0] seconds = '0;
  logic       serial_out, busy, done;

  game_status_tx #(.CLKS_PER_BIT(C)) dut (
    .clk            (clk),
    .reset          (reset),
    .send           (send_r),
    .p1_lives       (p1_lives),
    .p2_lives       (p2_lives),
    .player_1_pos   (p1_pos),
    .player_2_pos   (p2_pos),
    .correct_door_1 (door_1),
    .correct_door_2 (door_2),
    .time_up        (time_up),
    .seconds        (seconds),
    .serial_out     (serial_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_byte_q[$];
  int         exp_start_q[$];
  int         exp_done_q[$];
  int         next_free = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event with nothing expected at cycle %0d", name, cyc);
  endtask

  // Reference packet built from field arithmetic.
  task automatic model_push();
    int b1, b2, b3;
    b1 = int'(p1_lives) * 64 + int'(p2_lives) * 16 + int'(p1_pos) * 4 + int'(p2_pos);
    b2 = int'(door_1) * 64 + int'(door_2) * 16;
    b3 = int'(time_up) * 128 + int'(seconds);
    exp_byte_q.push_back(8'hA5);
    exp_byte_q.push_back(8'(b1));
    exp_byte_q.push_back(8'(b2));
    exp_byte_q.push_back(8'(b3));
    exp_byte_q.push_back(8'(b1 ^ b2 ^ b3));
  endtask

  task automatic randomize_inputs();
    p1_lives = 2'($urandom_range(3));
    p2_lives = 2'($urandom_range(3));
    p1_pos   = 2'($urandom_range(3));
    p2_pos   = 2'($urandom_range(3));
    door_1   = 2'($urandom_range(3));
    door_2   = 2'($urandom_range(3));
    time_up  = 1'($urandom_range(1));
    seconds  = 4'($urandom_range(15));
  endtask

  task automatic set_fields(input int a, input int b, input int c, input int d,
                            input int e, input int f, input int g, input int s);
    p1_lives = 2'(a); p2_lives = 2'(b); p1_pos = 2'(c); p2_pos = 2'(d);
    door_1 = 2'(e); door_2 = 2'(f); time_up = 1'(g); seconds = 4'(s);
  endtask

  // One-cycle send; inputs are scrambled the cycle after to prove the snapshot.
  task automatic issue();
    send_r = 1'b1;
    if (cyc >= next_free) begin
      model_push();
      exp_start_q.push_back(cyc + 1);
      exp_done_q.push_back(cyc + PKT_CYC + 1);
      next_free = cyc + PKT_CYC + 1;
    end
    @(posedge clk); #1;
    send_r = 1'b0;
    randomize_inputs();
  endtask

  task automatic rst(input int n);
    reset = 1'b1;
    exp_byte_q.delete();
    exp_start_q.delete();
    exp_done_q.delete();
    next_free = 0;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      chk("reset_line", 32'(serial_out), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < next_free + 3) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int d);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) flag("done_timeout");
    d = cyc;
  endtask

  task automatic check_drained(input string name);
    chk({name, "_bytes_left"}, 32'(exp_byte_q.size()), 32'd0);
    chk({name, "_dones_left"}, 32'(exp_done_q.size()), 32'd0);
  endtask

  // Line decoder and done/busy monitor, sampled mid-cycle.
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_rel = 0;
  int         mon_bidx = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    if (reset) begin
      mon_act  = 1'b0;
      mon_bidx = 0;
    end else begin
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) flag("done_pulse");
        else begin
          chk("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
      if (!mon_act) begin
        if (serial_out === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
          if (mon_bidx == 0) begin
            if (exp_start_q.size() == 0) flag("packet_start");
            else chk("start_cycle", 32'(cyc), 32'(exp_start_q.pop_front()));
            chk("busy_at_start", 32'(busy), 32'd1);
          end
        end
      end else begin
        mon_cnt++;
        mon_rel = mon_cnt - int'(H);
        if (mon_rel == 0) chk("start_bit", 32'(serial_out), 32'd0);
        if (mon_rel > 0 && mon_rel % int'(C) == 0 && mon_rel / int'(C) <= 8)
          mon_byte[3'(mon_rel / int'(C) - 1)] = serial_out;
        if (mon_rel == 9 * int'(C)) begin
          chk("stop_bit", 32'(serial_out), 32'd1);
          if (exp_byte_q.size() == 0) flag("byte_rx");
          else chk("byte_value", 32'(mon_byte), 32'(exp_byte_q.pop_front()));
          mon_act  = 1'b0;
          mon_bidx = (mon_bidx + 1) % 5;
        end
      end
    end
  end

  initial begin
    int a, d1, d2, off, gap;
    randomize_inputs();
    rst(3);
    repeat (20) begin
      @(negedge clk);
      chk("idle_line", 32'(serial_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // Basic packet: A5 B4 40 87 73
    @(posedge clk); #1;
    set_fields(2, 3, 1, 0, 1, 0, 1, 7);
    issue();
    wait_idle();
    check_drained("basic");

    // All-ones and all-zero field boundaries, seconds above 10.
    set_fields(3, 3, 3, 3, 3, 3, 1, 15);
    issue();
    wait_idle();
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    issue();
    wait_idle();
    check_drained("bounds");

    // Sends during a packet are dropped.
    randomize_inputs();
    a = cyc;
    issue();
    foreach (exp_start_q[i]) off = i;
    for (int k = 0; k < 3; k++) begin
      off = (k == 0) ? 10 : (k == 1) ? 50 : 150;
      while (cyc < a + off) begin @(posedge clk); #1; end
      randomize_inputs();
      issue();
    end
    wait_idle();
    repeat (20) begin
      @(negedge clk);
      chk("after_done_line", 32'(serial_out), 32'd1);
    end
    check_drained("reject");

    // Back-to-back: send accepted in the done cycle.
    @(posedge clk); #1;
    randomize_inputs();
    issue();
    wait_done(d1);
    randomize_inputs();
    issue();
    wait_done(d2);
    chk("b2b_done_gap", 32'(d2 - d1), 32'(PKT_CYC + 1));
    wait_idle();
    check_drained("b2b");

    // Reset inside byte 2 discards the packet; a fresh one follows cleanly.
    randomize_inputs();
    a = cyc;
    issue();
    while (cyc < a + 92) begin @(posedge clk); #1; end
    rst(2);
    repeat (300) @(negedge clk);
    @(posedge clk); #1;
    randomize_inputs();
    issue();
    wait_idle();
    check_drained("post_reset");

    // Random packets with occasional dropped sends.
    for (int r = 0; r < 6; r++) begin
      gap = int'($urandom_range(20));
      repeat (gap) @(posedge clk);
      #1;
      randomize_inputs();
      a = cyc;
      issue();
      if ($urandom_range(1) == 1) begin
        off = int'($urandom_range(195, 1));
        while (cyc < a + off) begin @(posedge clk); #1; end
        randomize_inputs();
        issue();
      end
      wait_idle();
    end
    check_drained("random");
    chk("starts_left", 32'(exp_start_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
